// File: rtl/jtframe_nvram_upload.sv
// Serves byte reads from the io controller out of 16-bit game NVRAM.
// A single-word cache absorbs the paired even/odd byte reads that an upload issues.
module jtframe_nvram_upload #(
    parameter int         AW      = 12,
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] FILL    = 8'hFF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          ioctl_ram,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_data2sd,
    output logic          ioctl_dok,
    output logic          busy,
    output logic [AW-1:0] nv_addr,
    output logic          nv_rd,
    input  logic          nv_ack,
    input  logic [15:0]   nv_din,
    input  logic          nv_we,
    output logic          err
);

    // state | meaning
    // IDLE  | waiting for ioctl_rd
    // WAIT  | nv_rd raised, waiting for nv_ack or timeout
    // OUT   | present the byte and pulse ioctl_dok
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

    localparam int CW = $clog2(TIMEOUT + 1) + 1;

    state_t          state;
    logic            ram_l;
    logic            cache_ok;
    logic [AW-1:0]   cache_addr;
    logic [15:0]     cache_data;
    logic [CW-1:0]   cnt;
    logic            byte_sel;
    logic [7:0]      out_byte;

    logic            ram_fall, ram_rise, out_range, hit;
    logic [AW-1:0]   req_waddr;
    logic [7:0]      hit_byte;

    assign ram_fall  = ram_l & ~ioctl_ram;
    assign ram_rise  = ~ram_l & ioctl_ram;
    assign req_waddr = ioctl_addr[AW:1];
    assign out_range = |ioctl_addr[24:AW+1];
    // a same-cycle write or upload start must not be served from a stale cache
    assign hit       = cache_ok & ~nv_we & ~ram_rise & (cache_addr == req_waddr);
    assign hit_byte  = ioctl_addr[0] ? cache_data[15:8] : cache_data[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ram_l         <= 1'b0;
            cache_ok      <= 1'b0;
            cache_addr    <= '0;
            cache_data    <= '0;
            cnt           <= '0;
            byte_sel      <= 1'b0;
            out_byte      <= '0;
            ioctl_data2sd <= '0;
            ioctl_dok     <= 1'b0;
            busy          <= 1'b0;
            nv_addr       <= '0;
            nv_rd         <= 1'b0;
            err           <= 1'b0;
        end else begin
            ram_l     <= ioctl_ram;
            ioctl_dok <= 1'b0;
            if (nv_we) cache_ok <= 1'b0;
            if (ram_fall) begin
                state    <= IDLE;
                nv_rd    <= 1'b0;
                busy     <= 1'b0;
                cache_ok <= 1'b0;
                err      <= 1'b0;
                cnt      <= '0;
            end else begin
                if (ram_rise) begin
                    err      <= 1'b0;
                    cache_ok <= 1'b0;
                end
                case (state)
                    IDLE: if (ioctl_rd && ioctl_ram) begin
                        busy     <= 1'b1;
                        byte_sel <= ioctl_addr[0];
                        if (out_range) begin
                            out_byte <= FILL;
                            state    <= OUT;
                        end else if (hit) begin
                            out_byte <= hit_byte;
                            state    <= OUT;
                        end else begin
                            nv_addr <= req_waddr;
                            nv_rd   <= 1'b1;
                            cnt     <= '0;
                            state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (nv_ack) begin
                            cache_data <= nv_din;
                            cache_addr <= nv_addr;
                            cache_ok   <= ~nv_we;
                            nv_rd      <= 1'b0;
                            out_byte   <= byte_sel ? nv_din[15:8] : nv_din[7:0];
                            state      <= OUT;
                        end else if (cnt == CW'(TIMEOUT)) begin
                            nv_rd    <= 1'b0;
                            err      <= 1'b1;
                            out_byte <= FILL;
                            state    <= OUT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    OUT: begin
                        ioctl_data2sd <= out_byte;
                        ioctl_dok     <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_nvram_upload.sv
// Directed bench for jtframe_nvram_upload: a vector table of byte requests
// followed by hand-written snoop, abort, busy, ram-low and reset sequences.
module tb_jtframe_nvram_upload;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioctl_ram;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_data2sd;
    logic        ioctl_dok;
    logic        busy;
    logic [11:0] nv_addr;
    logic        nv_rd;
    logic        nv_ack;
    logic [15:0] nv_din;
    logic        nv_we;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit we_on_ack = 1'b0;

    jtframe_nvram_upload #(.AW(12), .TIMEOUT(8), .FILL(8'hFF)) dut (
        .clk(clk), .rst(rst), .ioctl_ram(ioctl_ram), .ioctl_addr(ioctl_addr),
        .ioctl_rd(ioctl_rd), .ioctl_data2sd(ioctl_data2sd), .ioctl_dok(ioctl_dok),
        .busy(busy), .nv_addr(nv_addr), .nv_rd(nv_rd), .nv_ack(nv_ack),
        .nv_din(nv_din), .nv_we(nv_we), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        int          d;      // ack delay in cycles after nv_rd, -1 = never
        logic [15:0] din;
        logic [7:0]  eb;
        int          elat;
        bit          enr;
        logic [11:0] ena;
        bit          eerr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [24:0] a, input int d, input logic [15:0] din,
                          output logic [7:0] b, output int lat, output bit seen,
                          output logic [11:0] na, output int ndok);
        int wc;
        wc = 0; lat = -1; seen = 1'b0; na = '0; ndok = 0; b = 8'h00;
        @(negedge clk); ioctl_addr = a; ioctl_rd = 1'b1;
        @(negedge clk); ioctl_rd = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            nv_ack = 1'b0;
            nv_we  = 1'b0;
            if (ioctl_dok) begin
                ndok++;
                if (lat < 0) begin lat = k; b = ioctl_data2sd; end
            end
            if (nv_rd) begin
                if (!seen) na = nv_addr;
                seen = 1'b1;
                wc++;
                if (d >= 0 && wc == d + 1) begin
                    nv_ack = 1'b1;
                    nv_din = din;
                    nv_we  = we_on_ack;
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
        end
    endtask

    vec_t        v[10];
    logic [7:0]  b;
    int          lat, ndok;
    bit          seen;
    logic [11:0] na;

    initial begin
        v[0] = '{25'h0010,  2, 16'hBEEF, 8'hEF,  5, 1'b1, 12'h008, 1'b0};
        v[1] = '{25'h0011, -1, 16'h0000, 8'hBE,  2, 1'b0, 12'h000, 1'b0};
        v[2] = '{25'h2000, -1, 16'h0000, 8'hFF,  2, 1'b0, 12'h000, 1'b0};
        v[3] = '{25'h0010, -1, 16'h0000, 8'hEF,  2, 1'b0, 12'h000, 1'b0};
        v[4] = '{25'h1FFF,  0, 16'h1234, 8'h12,  3, 1'b1, 12'hFFF, 1'b0};
        v[5] = '{25'h1FFE, -1, 16'h0000, 8'h34,  2, 1'b0, 12'h000, 1'b0};
        v[6] = '{25'h0020,  1, 16'hA55A, 8'h5A,  4, 1'b1, 12'h010, 1'b0};
        v[7] = '{25'h0011,  0, 16'hCAFE, 8'hCA,  3, 1'b1, 12'h008, 1'b0};
        v[8] = '{25'h0040, -1, 16'h0000, 8'hFF, 11, 1'b1, 12'h020, 1'b1};
        v[9] = '{25'h0010, -1, 16'h0000, 8'hFE,  2, 1'b0, 12'h000, 1'b1};

        rst = 1'b1; ioctl_ram = 1'b0; ioctl_addr = '0; ioctl_rd = 1'b0;
        nv_ack = 1'b0; nv_din = '0; nv_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data2sd", ioctl_data2sd, 0);
        chk("rst_dok", ioctl_dok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nv_rd", nv_rd, 0);
        chk("rst_nv_addr", nv_addr, 0);
        chk("rst_err", err, 0);
        rst = 1'b0; ioctl_ram = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_req(v[i].addr, v[i].d, v[i].din, b, lat, seen, na, ndok);
            chk($sformatf("v%0d_byte", i), b, v[i].eb);
            chk($sformatf("v%0d_lat", i), lat, v[i].elat);
            chk($sformatf("v%0d_nv_rd", i), seen, v[i].enr);
            if (v[i].enr) chk($sformatf("v%0d_nv_addr", i), na, v[i].ena);
            chk($sformatf("v%0d_ndok", i), ndok, 1);
            chk($sformatf("v%0d_err", i), err, v[i].eerr);
            chk($sformatf("v%0d_busy", i), busy, 0);
        end

        // write snoop invalidates the cached word 0x008
        @(negedge clk); nv_we = 1'b1;
        @(negedge clk); nv_we = 1'b0;
        do_req(25'h0010, 0, 16'h1111, b, lat, seen, na, ndok);
        chk("snoop_nv_rd", seen, 1);
        chk("snoop_byte", b, 8'h11);
        chk("snoop_lat", lat, 3);

        // write coinciding with ack leaves the fresh word invalid
        we_on_ack = 1'b1;
        do_req(25'h0030, 0, 16'h7788, b, lat, seen, na, ndok);
        we_on_ack = 1'b0;
        chk("weack_byte", b, 8'h88);
        do_req(25'h0031, 0, 16'h99AA, b, lat, seen, na, ndok);
        chk("weack_refetch", seen, 1);
        chk("weack_byte2", b, 8'h99);

        // rd while busy ignored, then ioctl_ram falls during WAIT
        @(negedge clk); ioctl_addr = 25'h0050; ioctl_rd = 1'b1;
        @(negedge clk); ioctl_rd = 1'b0;
        chk("abort_nv_rd_on", nv_rd, 1);
        chk("abort_busy_on", busy, 1);
        chk("abort_err_before", err, 1);
        ioctl_addr = 25'h2000; ioctl_rd = 1'b1;
        @(negedge clk); ioctl_rd = 1'b0; ioctl_ram = 1'b0;
        @(negedge clk);
        chk("abort_nv_rd", nv_rd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        ndok = 0;
        for (int k = 0; k < 6; k++) begin
            if (ioctl_dok) ndok++;
            @(negedge clk);
        end
        chk("abort_no_dok", ndok, 0);

        // requests with ioctl_ram low are ignored
        ioctl_addr = 25'h0010; ioctl_rd = 1'b1;
        @(negedge clk); ioctl_rd = 1'b0;
        ndok = 0;
        for (int k = 0; k < 4; k++) begin
            if (ioctl_dok || busy || nv_rd) ndok++;
            @(negedge clk);
        end
        chk("ram_low_ignored", ndok, 0);
        ioctl_ram = 1'b1;
        repeat (2) @(negedge clk);

        // cache was invalidated by the abort
        do_req(25'h0031, 0, 16'h5566, b, lat, seen, na, ndok);
        chk("post_abort_miss", seen, 1);
        chk("post_abort_byte", b, 8'h55);

        // reset during WAIT
        @(negedge clk); ioctl_addr = 25'h0060; ioctl_rd = 1'b1;
        @(negedge clk); ioctl_rd = 1'b0;
        @(negedge clk);
        chk("rstw_nv_rd_on", nv_rd, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_nv_rd", nv_rd, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_nv_addr", nv_addr, 0);
        chk("rstw_data2sd", ioctl_data2sd, 0);
        chk("rstw_err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ndok = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ioctl_dok || nv_rd || busy) ndok++;
        end
        chk("rstw_quiet", ndok, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
